shift_rotate_pipe: RTL and testbench
====================================

Name: shift_rotate_pipe

Overview:
- Parametrised, pipelined barrel shifter/rotator, successor to the team's 8-bit combinational left/right shifter.
- Generalised data width; per-transaction mode select (logical left, logical right, arithmetic right, rotate right).
- One register stage per shift-amount bit, with valid/ready flow control on both sides.
- Sits between an operand source and an ALU/result bus; sustains one operation per cycle under backpressure.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, >= 2.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth (LEVELS = SHW); derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- in_data  in  WIDTH  operand
- in_amt  in  SHW  shift/rotate amount, 0..WIDTH-1
- in_mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_carry  out  1  last bit shifted out; present only with SHIFT_CARRY_EN

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, all stage data/ctrl = 0; out_valid = 0, out_data = 0, out_carry = 0; in_ready = 1 after reset.
- Pipeline: stages 0..SHW-1. Stage k applies a shift by 2^k when amt[k] = 1, else passes data through. Data, remaining amt and mode are registered at each stage.
- Latency: SHW cycles from an accepted input (in_valid & in_ready at edge) to out_valid, with no stalls. Throughput is 1 per cycle.
- Ready chain: stage k may load when its valid = 0 or stage k+1 loads (stage SHW-1 loads when out_valid = 0 or out_ready = 1). in_ready = load-enable of stage 0. This is a purely combinational backward path; no bubbles are inserted when the pipe is full and streaming.
- Stall: when out_valid = 1 and out_ready = 0, out_data/out_carry hold stable. Upstream stages fill their empty slots, then in_ready drops. No data is lost or duplicated.
- Simultaneous fire: when the output is consumed and the input accepted in the same cycle with the pipe full, the pipe advances by one and remains full.
- Modes:
  - LSL: zero fill at LSB.
  - LSR: zero fill at MSB.
  - ASR: fill with in_data[WIDTH-1].
  - ROR: bits exiting the LSB re-enter at the MSB.
- Amount 0: out_data = in_data in every mode.
- in_amt is never >= WIDTH, by construction of its width.
- in_data/in_amt/in_mode are sampled only on fire; other values while in_valid = 0 are ignored.
- Reset mid-operation: all in-flight transactions are discarded; no out_valid pulse follows reset release until a new input fires.

Optional Feature:
- Macro SHIFT_CARRY_EN.
- Defined:
  - out_carry port exists.
  - Carry is computed at stage 0 from the original operand and amount, then pipelined alongside the data.
  - LSL: in_data[WIDTH-amt].
  - LSR/ASR: in_data[amt-1].
  - ROR: result MSB, i.e. in_data[amt-1].
  - amt = 0: carry 0.
- Undefined: port and carry registers are absent; all other behaviour is identical.

Decomposition:
- Package shift_pkg:
  - mode encoding typedef (MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROR).
  - localparam for mode width (2).
- Sub-module shift_stage (parameters WIDTH, DIST):
  - one fixed-distance conditional shift plus its valid/data/ctrl register and load logic.
  - instantiated SHW times via generate.

Test Plan (WIDTH=8 unless stated):
- 8'hFB, amt 4, LSL -> out_data 8'hB0 after exactly 3 cycles; carry 1.
- 8'hF1, amt 2, LSR -> 8'h3C, carry 0. Same operand ASR -> 8'hFC.
- 8'hE7, amt 1, ASR -> 8'hF3, carry 1. 8'hBF, amt 3, ROR -> 8'hF7, carry 1.
- Back-to-back stream of 8 inputs with out_ready = 1 -> 8 results on consecutive cycles, in order, in_ready never low. Then out_ready = 0 for 5 cycles -> out_data held, in_ready low once 3 entries are buffered, no loss on release.
- Reset asserted with 2 transactions in flight -> out_valid = 0 immediately and stays 0 after release until a new input fires. Amt 0 in all four modes -> out_data = in_data, carry 0.
- WIDTH=32: 32'h8000_0001 ROR 1 -> 32'hC000_0000. 32'h8000_0000 ASR 31 -> 32'hFFFF_FFFF. Latency is 5 cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode encoding shared by the shift/rotate pipeline
package shift_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one fixed-distance conditional shift plus its pipeline register
// The carry register exists only when SHIFT_CARRY_EN is defined.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  shift_mode_e              in_mode,
`ifdef SHIFT_CARRY_EN
  input  logic                     in_carry,
  output logic                     out_carry,
`endif
  input  logic                     next_load,
  output logic                     load,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_amt,
  output shift_mode_e              out_mode
);

  localparam int BIT = $clog2(DIST);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] result;

  always_comb begin
    shifted = in_data;
    case (in_mode)
      MODE_LSL: shifted = in_data << DIST;
      MODE_LSR: shifted = in_data >> DIST;
      MODE_ASR: shifted = $signed(in_data) >>> DIST;
      default:  shifted = (in_data >> DIST) | (in_data << (WIDTH - DIST));
    endcase
    result = in_amt[BIT] ? shifted : in_data;
  end

  // A slot can take new contents when it is empty or its occupant moves on.
  assign load = ~out_valid | next_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_mode  <= MODE_LSL;
`ifdef SHIFT_CARRY_EN
      out_carry <= 1'b0;
`endif
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data  <= result;
        out_amt   <= in_amt;
        out_mode  <= in_mode;
`ifdef SHIFT_CARRY_EN
        out_carry <= in_carry;
`endif
      end
    end
  end

endmodule

// File: rtl/shift_rotate_pipe.sv
// rtl/shift_rotate_pipe.sv - pipelined barrel shifter/rotator, one stage per amount bit
// Optional SHIFT_CARRY_EN adds out_carry (last bit shifted out), pipelined with the data.
module shift_rotate_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_amt,
  input  logic [MODE_W-1:0] in_mode,
`ifdef SHIFT_CARRY_EN
  output logic              out_carry,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
);

  // Index 0 is the input side; index k+1 is the register of stage k.
  logic             valid [SHW+1];
  logic [WIDTH-1:0] data  [SHW+1];
  logic [SHW-1:0]   amt   [SHW+1];
  shift_mode_e      mode  [SHW+1];
  logic             load  [SHW+1];

  assign valid[0]  = in_valid;
  assign data[0]   = in_data;
  assign amt[0]    = in_amt;
  assign mode[0]   = shift_mode_e'(in_mode);
  assign load[SHW] = out_ready;

`ifdef SHIFT_CARRY_EN
  logic           carry [SHW+1];
  logic [SHW-1:0] lsl_idx;
  logic [SHW-1:0] rsh_idx;
  logic           carry_in;

  // WIDTH is a power of two, so the SHW-bit negation of amt is WIDTH-amt for amt > 0.
  always_comb begin
    lsl_idx  = -in_amt;
    rsh_idx  = in_amt - SHW'(1);
    carry_in = 1'b0;
    if (in_amt != '0) begin
      carry_in = (in_mode == MODE_LSL) ? in_data[lsl_idx] : in_data[rsh_idx];
    end
  end

  assign carry[0]  = carry_in;
  assign out_carry = carry[SHW];
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid[k]),
      .in_data   (data[k]),
      .in_amt    (amt[k]),
      .in_mode   (mode[k]),
`ifdef SHIFT_CARRY_EN
      .in_carry  (carry[k]),
      .out_carry (carry[k+1]),
`endif
      .next_load (load[k+1]),
      .load      (load[k]),
      .out_valid (valid[k+1]),
      .out_data  (data[k+1]),
      .out_amt   (amt[k+1]),
      .out_mode  (mode[k+1])
    );
  end

  assign in_ready  = load[0];
  assign out_valid = valid[SHW];
  assign out_data  = data[SHW];

  logic unused_tail;
  assign unused_tail = ^{amt[SHW], mode[SHW]};

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// tb/tb_shift_rotate_pipe.sv - self-checking bench for shift_rotate_pipe (WIDTH 8 and 32)
module tb_shift_rotate_pipe;

  localparam int W    = 8;
  localparam int SH   = 3;
  localparam int W32  = 32;
  localparam int SH32 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [SH-1:0] in_amt;
  logic [1:0]    in_mode;
  logic          out_carry;

  logic            in_valid32, in_ready32, out_valid32, out_ready32;
  logic [W32-1:0]  in_data32, out_data32;
  logic [SH32-1:0] in_amt32;
  logic [1:0]      in_mode32;
  logic            out_carry32;

  shift_rotate_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
`ifdef SHIFT_CARRY_EN
    .out_carry (out_carry),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  shift_rotate_pipe #(.WIDTH(W32)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_data   (in_data32),
    .in_amt    (in_amt32),
    .in_mode   (in_mode32),
`ifdef SHIFT_CARRY_EN
    .out_carry (out_carry32),
`endif
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out_data  (out_data32)
  );

`ifndef SHIFT_CARRY_EN
  assign out_carry   = 1'b0;
  assign out_carry32 = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stalls   = 0;
  bit head_seen = 1'b0;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    int           fire_cyc;
    int           stalls;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Bit-by-bit statement of the four modes: where does each result bit come from.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt, input int mode, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (mode)
        0:       r[i] = (i - amt >= 0) ? d[i-amt] : 1'b0;
        1:       r[i] = (i + amt < w) ? d[i+amt] : 1'b0;
        2:       r[i] = (i + amt < w) ? d[i+amt] : d[w-1];
        default: r[i] = d[(i + amt) % w];
      endcase
    end
    return r;
  endfunction

  function automatic logic ref_carry(input logic [31:0] d, input int amt, input int mode, input int w);
    if (amt == 0) return 1'b0;
    if (mode == 0) return d[w-amt];
    return d[amt-1];
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: every valid output cycle must show the oldest outstanding result.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      head_seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out_valid: got out_valid=1, required 0 (nothing outstanding)");
        end else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            if (stalls == q[0].stalls) check("latency", 32'(cyc - q[0].fire_cyc), SH);
            else check("latency_min", 32'((cyc - q[0].fire_cyc) >= SH), 1);
          end
          check("out_data", 32'(out_data), 32'(q[0].data));
`ifdef SHIFT_CARRY_EN
          check("out_carry", 32'(out_carry), 32'(q[0].carry));
`endif
          if (out_ready) begin
            void'(q.pop_front());
            head_seen = 1'b0;
          end else begin
            stalls++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.data     = W'(ref_shift(32'(in_data), int'(in_amt), int'(in_mode), W));
        e.carry    = ref_carry(32'(in_data), int'(in_amt), int'(in_mode), W);
        e.fire_cyc = cyc;
        e.stalls   = stalls;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input int a, input int m);
    in_valid = v;
    in_data  = d;
    in_amt   = a[SH-1:0];
    in_mode  = m[1:0];
  endtask

  task automatic one8(input string name, input logic [7:0] d, input int a, input int m,
                      input logic [7:0] exp_d, input logic exp_c);
    int k;
    check({name, "_model"}, ref_shift(32'(d), a, m, W), 32'(exp_d));
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, d, a, m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
    end
    check({name, "_lat"}, 32'(k), SH);
    check({name, "_data"}, 32'(out_data), 32'(exp_d));
`ifdef SHIFT_CARRY_EN
    check({name, "_carry"}, 32'(out_carry), 32'(exp_c));
`else
    if (exp_c === 1'bx) $display("unused carry expectation");
`endif
  endtask

  task automatic one32(input string name, input logic [31:0] d, input int a, input int m,
                       input logic [31:0] exp_d, input logic exp_c);
    int k;
    check({name, "_model"}, ref_shift(d, a, m, W32), exp_d);
    @(posedge clk); #1;
    in_valid32 = 1'b1;
    in_data32  = d;
    in_amt32   = a[SH32-1:0];
    in_mode32  = m[1:0];
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (out_valid32) break;
    end
    check({name, "_lat"}, 32'(k), SH32);
    check({name, "_data"}, out_data32, exp_d);
`ifdef SHIFT_CARRY_EN
    check({name, "_carry"}, 32'(out_carry32), 32'(exp_c));
`else
    if (exp_c === 1'bx) $display("unused carry expectation");
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 0, 0);
    out_ready   = 1'b0;
    in_valid32  = 1'b0;
    in_data32   = '0;
    in_amt32    = '0;
    in_mode32   = '0;
    out_ready32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_carry", 32'(out_carry), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 1);
    check("post_rst_out_valid", 32'(out_valid), 0);

    one8("lsl_fb_4", 8'hFB, 4, 0, 8'hB0, 1'b1);
    one8("lsr_f1_2", 8'hF1, 2, 1, 8'h3C, 1'b0);
    one8("asr_f1_2", 8'hF1, 2, 2, 8'hFC, 1'b0);
    one8("asr_e7_1", 8'hE7, 1, 2, 8'hF3, 1'b1);
    one8("ror_bf_3", 8'hBF, 3, 3, 8'hF7, 1'b1);
    for (int m = 0; m < 4; m++) one8("amt0", 8'hA5, 0, m, 8'hA5, 1'b0);

    // Back-to-back stream with the consumer always ready.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, W'($urandom), $urandom_range(0, 7), $urandom_range(0, 3));
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (SH + 2) @(posedge clk);
    #1;

    // Consumer blocked: exactly three entries are absorbed, then in_ready drops.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, W'($urandom), $urandom_range(0, 7), $urandom_range(0, 3));
      @(negedge clk);
      check("fill_in_ready", 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (SH + 3) @(posedge clk);
    #1;
    check("fill_drained", 32'(q.size()), 0);

    // Reset with two transactions in flight and a blocked consumer.
    out_ready = 1'b0;
    drive(1'b1, 8'h3C, 1, 0);
    @(posedge clk); #1;
    drive(1'b1, 8'h81, 7, 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_data", 32'(out_data), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("after_rst_quiet", 32'(out_valid), 0);
    end
    one8("after_rst_lsr", 8'h80, 7, 1, 8'h01, 1'b0);

    // Randomized traffic with random backpressure, checked by the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_amt    = SH'($urandom);
      in_mode   = 2'($urandom);
      out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("random_drained", 32'(q.size()), 0);

    one32("ror32_1", 32'h8000_0001, 1, 3, 32'hC000_0000, 1'b1);
    one32("asr32_31", 32'h8000_0000, 31, 2, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      int a, m;
      d = $urandom;
      a = $urandom_range(0, 31);
      m = $urandom_range(0, 3);
      one32("rand32", d, a, m, ref_shift(d, a, m, W32), ref_carry(d, a, m, W32));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
